// File: rtl/sample_fetcher.sv
// Consumer side of the generate_next / sample_ready handshake: requests one sample
// per codec frame, waits with a timeout, then emits a volume-scaled valid pulse.
module sample_fetcher #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_frame,
  input  logic [2:0]       volume,
  output logic             generate_next,
  input  logic             sample_ready,
  input  logic [WIDTH-1:0] sample_in,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             timeout_err,
  output logic             frame_overrun,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] scaled;
  logic [2:0]       shamt;
  logic             ready_hit;
  logic             time_up;

  assign ready_hit = (state == WAIT) && sample_ready;
  assign time_up   = (state == WAIT) && !sample_ready && (count == LAST);

  // A timeout re-scales the last good sample with whatever volume is current.
  assign src    = ready_hit ? sample_in : raw;
  assign shamt  = 3'd7 - volume;
  assign scaled = $signed(src) >>> shamt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (new_frame) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (ready_hit || time_up) state_next = DONE;
      DONE:    state_next = new_frame ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      raw   <= '0;
    end else begin
      if (state == REQ)
        count <= '0;
      else if (state == WAIT && state_next == WAIT)
        count <= count + 1'b1;
      if (ready_hit)
        raw <= sample_in;
    end
  end

  // Outputs are registered from the next state so none is combinational from inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      generate_next <= 1'b0;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      timeout_err   <= 1'b0;
      frame_overrun <= 1'b0;
      sample_out    <= '0;
    end else begin
      generate_next <= (state_next == REQ);
      busy          <= (state_next == REQ) || (state_next == WAIT);
      sample_valid  <= (state_next == DONE);
      timeout_err   <= time_up;
      frame_overrun <= new_frame && ((state == REQ) || (state == WAIT));
      if (state == WAIT && state_next == DONE)
        sample_out <= scaled;
    end
  end

endmodule

// File: tb/tb_sample_fetcher.sv
// Self-checking bench for sample_fetcher: table vectors, hand sequences for
// back-to-back and mid-request reset, then randomized frames against a timeline model.
module tb_sample_fetcher;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             new_frame;
  logic [2:0]       volume;
  logic             generate_next;
  logic             sample_ready;
  logic [WIDTH-1:0] sample_in;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic             timeout_err;
  logic             frame_overrun;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] hold_out  = 16'h0000;
  logic [15:0] model_raw = 16'h0000;

  typedef struct {
    logic [15:0] smp;
    logic [2:0]  vol;
    int          lat;
    int          extra;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[9];

  sample_fetcher #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_frame    (new_frame),
    .volume       (volume),
    .generate_next(generate_next),
    .sample_ready (sample_ready),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .frame_overrun(frame_overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Floor division by a power of two, i.e. arithmetic right shift with sign.
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [2:0] v);
    int val;
    int d;
    val = int'($signed(s));
    d = 1 << (7 - int'(v));
    if (val >= 0) val = val / d;
    else          val = -((-val + d - 1) / d);
    return val[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int k, input bit g, input bit b,
                           input bit v, input bit t, input bit o, input logic [15:0] so);
    check_output($sformatf("%s c%0d generate_next", tag, k), 16'(generate_next), 16'(g));
    check_output($sformatf("%s c%0d busy", tag, k), 16'(busy), 16'(b));
    check_output($sformatf("%s c%0d sample_valid", tag, k), 16'(sample_valid), 16'(v));
    check_output($sformatf("%s c%0d timeout_err", tag, k), 16'(timeout_err), 16'(t));
    check_output($sformatf("%s c%0d frame_overrun", tag, k), 16'(frame_overrun), 16'(o));
    check_output($sformatf("%s c%0d sample_out", tag, k), sample_out, so);
  endtask

  // One frame from IDLE: strobe at c0, generator answers at c(1+lat) (lat>TIMEOUT = silent
  // within the window), optional dropped strobe at c(extra). Checks c0..c(end+1).
  task automatic apply_stimulus(input string tag, input logic [15:0] smp, input logic [2:0] vol,
                                input int lat, input int extra, input logic [15:0] exp_out);
    int  end_c;
    bit  to;
    bit  ov;
    to    = (lat > TIMEOUT);
    end_c = to ? TIMEOUT + 2 : lat + 2;
    volume = vol;
    for (int k = 0; k <= end_c + 1; k++) begin
      new_frame = (k == 0) || (k == extra);
      if (k == 1 + lat) begin
        sample_ready = 1'b1;
        sample_in    = smp;
      end else if (k <= 1 && $urandom_range(0, 1) == 1) begin
        sample_ready = 1'b1;
        sample_in    = 16'($urandom);
      end else begin
        sample_ready = 1'b0;
        sample_in    = 16'($urandom);
      end
      @(negedge clk);
      ov = (extra >= 1) && (extra <= end_c - 1) && (k == extra + 1);
      check_all(tag, k, k == 1, (k >= 1) && (k < end_c), k == end_c,
                (k == end_c) && to, ov, (k >= end_c) ? exp_out : hold_out);
      step();
    end
    new_frame    = 1'b0;
    sample_ready = 1'b0;
    hold_out     = exp_out;
    if (!to) model_raw = smp;
  endtask

  initial begin
    vecs[0] = '{16'h4000, 3'd7, 2,  -1, 16'h4000};
    vecs[1] = '{16'h8000, 3'd4, 2,  -1, 16'hF000};
    vecs[2] = '{16'h7FFF, 3'd0, 2,  -1, 16'h00FF};
    vecs[3] = '{16'h1234, 3'd7, 2,  -1, 16'h1234};
    vecs[4] = '{16'hBEEF, 3'd7, 99, -1, 16'h1234};
    vecs[5] = '{16'h4000, 3'd7, 2,   2, 16'h4000};
    vecs[6] = '{16'hBEEF, 3'd3, 99, -1, 16'h0400};
    vecs[7] = '{16'h8000, 3'd6, 1,  -1, 16'hC000};
    vecs[8] = '{16'h0F00, 3'd7, TIMEOUT, -1, 16'h0F00};

    reset        = 1'b0;
    new_frame    = 1'b0;
    volume       = 3'd7;
    sample_ready = 1'b0;
    sample_in    = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0, 0, 16'h0000);
    step();
    reset = 1'b1;

    for (int i = 0; i < 9; i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i].smp, vecs[i].vol, vecs[i].lat,
                     vecs[i].extra, vecs[i].exp_out);

    // Back-to-back: second strobe lands in DONE and is serviced, not dropped.
    volume = 3'd7;
    for (int k = 0; k <= 9; k++) begin
      new_frame    = (k == 0) || (k == 4);
      sample_ready = (k == 3) || (k == 7);
      sample_in    = (k == 3) ? 16'h1111 : 16'h2222;
      @(negedge clk);
      check_all("b2b", k, (k == 1) || (k == 5),
                (k >= 1 && k <= 3) || (k >= 5 && k <= 7), (k == 4) || (k == 8), 0, 0,
                (k < 4) ? hold_out : ((k < 8) ? 16'h1111 : 16'h2222));
      step();
    end
    new_frame    = 1'b0;
    sample_ready = 1'b0;
    hold_out     = 16'h2222;
    model_raw    = 16'h2222;

    // Reset while waiting: outputs and raw cleared, late response ignored.
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check_all("rst_wait", 2, 0, 0, 0, 0, 0, 16'h0000);
    step();
    reset        = 1'b1;
    sample_ready = 1'b1;
    sample_in    = 16'h5555;
    @(negedge clk);
    check_all("rst_wait", 3, 0, 0, 0, 0, 0, 16'h0000);
    step();
    sample_ready = 1'b0;
    @(negedge clk);
    check_all("rst_wait", 4, 0, 0, 0, 0, 0, 16'h0000);
    step();
    hold_out  = 16'h0000;
    model_raw = 16'h0000;
    apply_stimulus("rst_raw", 16'hAAAA, 3'd7, 99, -1, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] smp;
      logic [2:0]  vol;
      int          lat;
      int          extra;
      int          end_c;
      logic [15:0] exp_out;
      smp = 16'($urandom);
      vol = 3'($urandom_range(0, 7));
      lat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TIMEOUT + 2))
                                        : int'($urandom_range(1, 4));
      end_c = (lat > TIMEOUT) ? TIMEOUT + 2 : lat + 2;
      extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, end_c - 1)) : -1;
      exp_out = (lat > TIMEOUT) ? scale(model_raw, vol) : scale(smp, vol);
      apply_stimulus($sformatf("rand%0d", i), smp, vol, lat, extra, exp_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
